// File: rtl/spad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spad_pkg
// Purpose  : Shared types and helpers for the scratchpad loader slice.
//            ld_state_t - load-command FSM states.
//            wrap_add   - pointer add with a single compare-subtract wrap.
// Revision : 1.0 - initial release
// ============================================================================
package spad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // Callers guarantee ptr < depth and inc <= depth, so a single subtract
    // is enough to bring the sum back into range.
    function automatic int wrap_add(input int ptr, input int inc, input int depth);
        int w_sum;
        w_sum = ptr + inc;
        if (w_sum >= depth) begin
            w_sum = w_sum - depth;
        end
        return w_sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spad_mem.sv
`default_nettype none
// ============================================================================
// Module   : spad_mem
// Purpose  : DEPTH x WIDTH scratchpad storage, one write port and one
//            synchronous read port, read-first on a same-address collision.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            we, waddr, wdata  - write port
//            re, raddr, rdata  - read port, rdata registered (1-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module spad_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Non-blocking semantics give the pre-write contents on a collision.
    // rdata holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/spad_loader.sv
`default_nettype none
// ============================================================================
// Module   : spad_loader
// Purpose  : Pops words from a show-ahead FIFO into a circular scratchpad
//            under a start/len command, serves offset reads from the head
//            and frees the oldest entries on release.
// Ports    : clk, rst                      - clock, sync active-high reset
//            start, len, done              - load command / completion pulse
//            fifo_valid, fifo_dout         - FIFO head word (show-ahead)
//            fifo_ren                      - pop strobe to the FIFO
//            rd_en, rd_off, rd_data,
//            rd_valid                      - offset read, 1-cycle latency
//            rel_en, rel_cnt               - release of oldest entries
//            count, full, empty            - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module spad_loader
    import spad_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int SPAD_DEPTH = 12,
    parameter  int LEN_WIDTH  = 8,
    localparam int AW         = $clog2(SPAD_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 done,
    input  logic                 fifo_valid,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_ren,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_off,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 rel_en,
    input  logic [LEN_WIDTH-1:0] rel_cnt,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [AW:0] c_depth = (AW+1)'(SPAD_DEPTH);

    ld_state_t            r_state;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic                 r_done;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_head;
    logic [AW:0]          r_count;
    logic                 r_rd_valid;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_rd_acc;
    logic [AW:0]          w_eff;
    logic [AW-1:0]        w_wr_next;
    logic [AW-1:0]        w_head_next;
    logic [AW-1:0]        w_rd_addr;

    // Full is the pre-edge value: a release in the same cycle cannot make
    // room for this cycle's pop.
    assign w_full = (r_count == c_depth);
    assign w_pop  = (r_state == LOAD) && fifo_valid && !w_full && (r_remaining != '0);

    // Over-release saturates at the current occupancy. Compared at 32 bits
    // so rel_cnt and count may have any relative widths.
    always_comb begin
        w_eff = '0;
        if (rel_en) begin
            if (32'(rel_cnt) >= 32'(r_count)) begin
                w_eff = r_count;
            end else begin
                w_eff = (AW+1)'(rel_cnt);
            end
        end
    end

    // Reads use the pre-edge head and count; a same-cycle release has no effect.
    assign w_rd_acc    = rd_en && ({1'b0, rd_off} < r_count);
    assign w_rd_addr   = AW'(wrap_add(int'(r_head), int'(rd_off), SPAD_DEPTH));
    assign w_wr_next   = AW'(wrap_add(int'(r_wr_ptr), 1, SPAD_DEPTH));
    assign w_head_next = AW'(wrap_add(int'(r_head), int'(w_eff), SPAD_DEPTH));

    // Load FSM. done is registered and asserted exactly while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_remaining <= len;
                        if (len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (w_pop) begin
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        // Last pop: done appears in the following cycle.
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Pointers, occupancy and read handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_head     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr_ptr <= w_wr_next;
            end
            r_head     <= w_head_next;
            r_count    <= r_count + (AW+1)'(w_pop) - w_eff;
            r_rd_valid <= w_rd_acc;
        end
    end

    spad_mem #(
        .WIDTH (WIDTH),
        .DEPTH (SPAD_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_pop),
        .waddr (r_wr_ptr),
        .wdata (fifo_dout),
        .re    (w_rd_acc),
        .raddr (w_rd_addr),
        .rdata (rd_data)
    );

    assign fifo_ren = w_pop;
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_spad_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spad_loader
// Purpose  : Self-checking bench for spad_loader. A queue-based model of the
//            scratchpad contents and load command predicts every output each
//            cycle; directed sequences add checks against fixed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spad_loader;

    localparam int DEPTH = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        done;
    logic        fifo_valid;
    logic [15:0] fifo_dout;
    logic        fifo_ren;
    logic        rd_en;
    logic [3:0]  rd_off;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rel_en;
    logic [7:0]  rel_cnt;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    spad_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .done       (done),
        .fifo_valid (fifo_valid),
        .fifo_dout  (fifo_dout),
        .fifo_ren   (fifo_ren),
        .rd_en      (rd_en),
        .rd_off     (rd_off),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rel_en     (rel_en),
        .rel_cnt    (rel_cnt),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int npops = 0;

    // Reference model: spad contents as a queue (front = oldest), FIFO as a queue.
    logic [15:0] mq[$];
    logic [15:0] src[$];
    bit          vgate;
    bit          m_idle, m_load, m_done;
    int          m_rem;
    bit          m_rdv;
    logic [15:0] m_rdd;

    typedef struct {
        logic [3:0]  off;
        bit          exp_v;
        logic [15:0] exp_d;
    } rd_vec_t;
    rd_vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idle = 1'b1;
        m_load = 1'b0;
        m_done = 1'b0;
        m_rem  = 0;
        m_rdv  = 1'b0;
        m_rdd  = '0;
    endtask

    // One clock cycle: inputs are already driven; check, clock, update model.
    task automatic step();
        bit ep;
        int eff;
        int sz;
        fifo_valid = vgate && (src.size() > 0);
        fifo_dout  = (src.size() > 0) ? src[0] : 16'hdead;
        #1;
        sz = mq.size();
        ep = m_load && fifo_valid && (sz < DEPTH) && (m_rem != 0);
        chk("fifo_ren", fifo_ren, ep);
        chk("count", count, sz);
        chk("full", full, sz == DEPTH);
        chk("empty", empty, sz == 0);
        chk("done", done, m_done);
        chk("rd_valid", rd_valid, m_rdv);
        chk("rd_data", rd_data, m_rdd);
        if (fifo_ren === 1'b1) npops++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (rd_en && (int'(rd_off) < sz)) begin
                m_rdv = 1'b1;
                m_rdd = mq[rd_off];
            end else begin
                m_rdv = 1'b0;
            end
            eff = 0;
            if (rel_en) eff = (int'(rel_cnt) < sz) ? int'(rel_cnt) : sz;
            repeat (eff) void'(mq.pop_front());
            if (ep) mq.push_back(src[0]);
            if (m_done) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end else if (m_idle && start) begin
                m_idle = 1'b0;
                if (len == 0) m_done = 1'b1;
                else begin
                    m_load = 1'b1;
                    m_rem  = len;
                end
            end else if (m_load && ep) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_load = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        if (ep) void'(src.pop_front());
        @(negedge clk);
    endtask

    task automatic wait_done(input int bound, input bit toggle);
        int g = 0;
        while (!m_done && g < bound) begin
            if (toggle) vgate = !vgate;
            step();
            g++;
        end
        total++;
        if (!m_done) begin
            bad++;
            $display("FAIL wait_done: no done within %0d cycles, expected done", bound);
        end else begin
            step();
        end
    endtask

    task automatic go(input int n);
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
    endtask

    task automatic release_n(input int n);
        rel_en  = 1'b1;
        rel_cnt = 8'(n);
        step();
        rel_en  = 1'b0;
    endtask

    initial begin
        tv[0] = '{4'd0, 1'b1, 16'd1};
        tv[1] = '{4'd1, 1'b1, 16'd2};
        tv[2] = '{4'd2, 1'b1, 16'd3};
        tv[3] = '{4'd3, 1'b1, 16'd4};
        tv[4] = '{4'd4, 1'b0, 16'd4};
        tv[5] = '{4'd1, 1'b1, 16'd2};
        tv[6] = '{4'd7, 1'b0, 16'd2};

        rst = 1'b1; start = 0; len = 0; rd_en = 0; rd_off = 0;
        rel_en = 0; rel_cnt = 0; vgate = 0; fifo_valid = 0; fifo_dout = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        @(negedge clk);

        // 1: basic load of 4 words, then table-driven reads
        for (int i = 1; i <= 4; i++) src.push_back(16'(i));
        vgate = 1; npops = 0;
        go(4);
        wait_done(20, 0);
        chk("t1_pops", npops, 4);
        chk("t1_count", count, 4);
        for (int i = 0; i < 7; i++) begin
            rd_en = 1; rd_off = tv[i].off;
            step();
            rd_en = 0;
            chk("t1_rd_valid", rd_valid, tv[i].exp_v);
            chk("t1_rd_data", rd_data, tv[i].exp_d);
        end
        release_n(4);
        chk("t1_rel_count", count, 0);

        // 2: over-length load stalls at full until a release
        for (int i = 0; i < 14; i++) src.push_back(16'(100 + i));
        npops = 0;
        go(14);
        repeat (16) step();
        #1;
        chk("t2_full_count", count, 12);
        chk("t2_full", full, 1);
        chk("t2_stall_ren", fifo_ren, 0);
        @(negedge clk);
        release_n(3);
        wait_done(20, 0);
        chk("t2_count", count, 11);
        chk("t2_pops", npops, 14);
        release_n(11);

        // 3: wrap from a fresh reset
        vgate = 0; rst = 1; step(); rst = 0;
        for (int i = 1; i <= 16; i++) src.push_back(16'(i));
        vgate = 1;
        go(10);
        wait_done(30, 0);
        release_n(8);
        go(6);
        wait_done(30, 0);
        chk("t3_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; rd_off = 4'(i);
            step();
            rd_en = 0;
            chk("t3_rd_data", rd_data, 9 + i);
        end
        release_n(8);

        // 4: release alongside a pop, then over-release
        for (int i = 0; i < 8; i++) src.push_back(16'(300 + i));
        go(8);
        for (int g = 0; g < 20 && count != 5; g++) step();
        rel_en = 1; rel_cnt = 2;
        step();
        chk("t4_pop_rel_count", count, 4);
        vgate = 0; rel_cnt = 9;
        step();
        rel_en = 0;
        chk("t4_over_rel_count", count, 0);
        chk("t4_over_rel_empty", empty, 1);
        vgate = 1;
        wait_done(20, 0);
        chk("t4_tail_count", count, 2);
        release_n(2);

        // 5: toggling fifo_valid; no dropped or duplicated words
        for (int i = 0; i < 10; i++) src.push_back(16'(200 + i));
        vgate = 0; npops = 0;
        go(10);
        wait_done(60, 1);
        vgate = 1;
        chk("t5_pops", npops, 10);
        for (int i = 0; i < 10; i++) begin
            rd_en = 1; rd_off = 4'(i);
            step();
            rd_en = 0;
            chk("t5_rd_data", rd_data, 200 + i);
        end
        rd_en = 1; rd_off = 4'd10;
        step();
        rd_en = 0;
        chk("t5_rej_valid", rd_valid, 0);
        chk("t5_rej_hold", rd_data, 209);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (src.size() < 4) src.push_back(16'($urandom));
            start   = ($urandom_range(0, 9) == 0);
            len     = 8'($urandom_range(0, 10));
            vgate   = ($urandom_range(0, 3) != 0);
            rel_en  = ($urandom_range(0, 3) == 0);
            rel_cnt = 8'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4));
            rd_en   = 1'($urandom_range(0, 1));
            rd_off  = 4'($urandom_range(0, 13));
            step();
        end
        start = 0; rel_en = 0; rd_en = 0;

        // 6: reset mid-load after 3 pops, then a clean load
        vgate = 0; rst = 1; step(); rst = 0;
        src.delete();
        for (int i = 0; i < 8; i++) src.push_back(16'(400 + i));
        vgate = 1; npops = 0;
        go(8);
        for (int g = 0; g < 20 && npops < 3; g++) step();
        vgate = 0; rst = 1;
        step();
        rst = 0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_done", done, 0);
        end
        src.delete();
        src.push_back(16'd50);
        src.push_back(16'd51);
        vgate = 1;
        go(2);
        wait_done(20, 0);
        chk("t6_count", count, 2);
        rd_en = 1; rd_off = 4'd1;
        step();
        rd_en = 0;
        chk("t6_rd_data", rd_data, 51);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
